// File: rtl/axi4_lite_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_pkg
// Brief    : Shared response codes, register offsets and FSM state types for
//            the AXI4-Lite register slave. Macro: AXI_SLAVE_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_lite_reg_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam logic [31:0] OFF_ID      = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS  = 32'h0000_0004;
    localparam logic [31:0] OFF_RW_BASE = 32'h0000_0008;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
`ifdef AXI_SLAVE_WAIT_EN
        , W_WAIT
`endif
    } write_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DATA
`ifdef AXI_SLAVE_WAIT_EN
        , R_WAIT
`endif
    } read_state_t;

    // Index width for an n-entry register array, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_if
// Brief    : AXI4-Lite bus bundle (32-bit address/data) with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_reg_decode.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_decode
// Brief    : Combinational byte-address decoder for the register window.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_reg_decode
    import axi4_lite_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          NUM_RW    = 8,
    parameter int          IDX_W     = 3
) (
    input  wire logic [31:0]      i_addr,
    output logic                  o_is_id,
    output logic                  o_is_status,
    output logic [IDX_W-1:0]      o_rw_idx,
    output logic                  o_err
);

    localparam logic [31:0] c_WIN_END = OFF_RW_BASE + 32'(4 * NUM_RW);

    logic [31:0] w_offset;

    assign w_offset    = i_addr - BASE_ADDR;
    assign o_err       = (i_addr < BASE_ADDR) || (i_addr[1:0] != 2'b00) ||
                         (w_offset >= c_WIN_END);
    assign o_is_id     = !o_err && (w_offset == OFF_ID);
    assign o_is_status = !o_err && (w_offset == OFF_STATUS);
    // Only meaningful when the access is neither an error nor ID/STATUS.
    assign o_rw_idx    = IDX_W'((w_offset - OFF_RW_BASE) >> 2);

endmodule
`default_nettype wire

// File: rtl/axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_slave
// Brief    : AXI4-Lite register block: ID, STATUS and NUM_RW control registers
//            with independent read/write FSMs. Macro: AXI_SLAVE_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_reg_slave
    import axi4_lite_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          NUM_RW      = 8,
    parameter logic [31:0] ID_VALUE    = 32'hA5A5_0001,
    parameter int          WAIT_CYCLES = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    axi4_lite_if.slave              axi,
    input  wire logic [31:0]        hw_status,
    output logic [NUM_RW*32-1:0]    reg_out,
    output logic [NUM_RW-1:0]       reg_wr_pulse
);

    localparam int IDX_W = idx_width(NUM_RW);

    write_state_t       r_wstate, w_wstate_nxt;
    read_state_t        r_rstate, w_rstate_nxt;
    logic [31:0]        r_awaddr, r_wdata, r_status, r_rdata;
    logic [3:0]         r_wstrb;
    logic               r_bvalid;
    logic [1:0]         r_bresp, r_rresp;
    logic [31:0]        r_regs [NUM_RW];

    logic               w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_bad, w_bvalid_set, w_rd_sample;
    logic               w_wr_is_id, w_wr_is_status, w_wr_err;
    logic               w_rd_is_id, w_rd_is_status, w_rd_err;
    logic [IDX_W-1:0]   w_wr_idx, w_rd_idx;
    logic [31:0]        w_rd_addr, w_rd_data;
    logic [1:0]         w_rd_resp;

    axi4_lite_reg_decode #(.BASE_ADDR(BASE_ADDR), .NUM_RW(NUM_RW), .IDX_W(IDX_W)) u_wr_dec (
        .i_addr(r_awaddr), .o_is_id(w_wr_is_id), .o_is_status(w_wr_is_status),
        .o_rw_idx(w_wr_idx), .o_err(w_wr_err)
    );

    axi4_lite_reg_decode #(.BASE_ADDR(BASE_ADDR), .NUM_RW(NUM_RW), .IDX_W(IDX_W)) u_rd_dec (
        .i_addr(w_rd_addr), .o_is_id(w_rd_is_id), .o_is_status(w_rd_is_status),
        .o_rw_idx(w_rd_idx), .o_err(w_rd_err)
    );

    assign axi.awready = !rst && ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_DATA));
    assign axi.wready  = !rst && ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_ADDR));
    assign axi.arready = !rst && (r_rstate == R_IDLE);
    assign axi.bvalid  = r_bvalid;
    assign axi.bresp   = r_bresp;
    assign axi.rvalid  = (r_rstate == R_DATA);
    assign axi.rdata   = r_rdata;
    assign axi.rresp   = r_rresp;

    assign w_aw_hs  = axi.awvalid && axi.awready;
    assign w_w_hs   = axi.wvalid && axi.wready;
    assign w_ar_hs  = axi.arvalid && axi.arready;
    // The first W_RESP cycle, before bvalid rises, is the commit cycle.
    assign w_commit = (r_wstate == W_RESP) && !r_bvalid;
    assign w_wr_bad = w_wr_err || w_wr_is_id || w_wr_is_status;

`ifdef AXI_SLAVE_WAIT_EN
    localparam logic [7:0] c_WAIT = 8'(WAIT_CYCLES);
    logic [7:0]  r_wcnt, r_rcnt;
    logic [31:0] r_araddr;
    logic        w_wwait_done, w_rwait_done;

    assign w_wwait_done = (r_wstate == W_WAIT) && (r_wcnt == 8'd1);
    assign w_rwait_done = (r_rstate == R_WAIT) && (r_rcnt == 8'd1);
    assign w_bvalid_set = (w_commit && (c_WAIT == 8'd0)) || w_wwait_done;
    assign w_rd_sample  = (w_ar_hs && (c_WAIT == 8'd0)) || w_rwait_done;
    assign w_rd_addr    = (r_rstate == R_WAIT) ? r_araddr : axi.araddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt   <= '0;
            r_rcnt   <= '0;
            r_araddr <= '0;
        end else begin
            if (w_commit)                  r_wcnt <= c_WAIT;
            else if (r_wstate == W_WAIT)   r_wcnt <= r_wcnt - 8'd1;
            if (w_ar_hs) begin
                r_rcnt   <= c_WAIT;
                r_araddr <= axi.araddr;
            end else if (r_rstate == R_WAIT) begin
                r_rcnt   <= r_rcnt - 8'd1;
            end
        end
    end
`else
    assign w_bvalid_set = w_commit;
    assign w_rd_sample  = w_ar_hs;
    assign w_rd_addr    = axi.araddr;
`endif

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) w_wstate_nxt = W_RESP;
                else if (w_aw_hs)      w_wstate_nxt = W_HAVE_ADDR;
                else if (w_w_hs)       w_wstate_nxt = W_HAVE_DATA;
            end
            W_HAVE_ADDR: if (w_w_hs)  w_wstate_nxt = W_RESP;
            W_HAVE_DATA: if (w_aw_hs) w_wstate_nxt = W_RESP;
            W_RESP: begin
                if (w_commit) begin
`ifdef AXI_SLAVE_WAIT_EN
                    if (c_WAIT != 8'd0) w_wstate_nxt = W_WAIT;
`endif
                end else if (axi.bready) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
`ifdef AXI_SLAVE_WAIT_EN
            W_WAIT: if (w_wwait_done) w_wstate_nxt = W_RESP;
`endif
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
`ifdef AXI_SLAVE_WAIT_EN
                    w_rstate_nxt = (c_WAIT == 8'd0) ? R_DATA : R_WAIT;
`else
                    w_rstate_nxt = R_DATA;
`endif
                end
            end
            R_DATA: if (axi.rready) w_rstate_nxt = R_IDLE;
`ifdef AXI_SLAVE_WAIT_EN
            R_WAIT: if (w_rwait_done) w_rstate_nxt = R_DATA;
`endif
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        if (!w_rd_err) begin
            w_rd_resp = RESP_OKAY;
            if (w_rd_is_id)          w_rd_data = ID_VALUE;
            else if (w_rd_is_status) w_rd_data = r_status;
            else                     w_rd_data = r_regs[w_rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            if (w_commit)                    r_bresp  <= w_wr_bad ? RESP_SLVERR : RESP_OKAY;
            if (w_bvalid_set)                r_bvalid <= 1'b1;
            else if (r_bvalid && axi.bready) r_bvalid <= 1'b0;
            if (w_rd_sample) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_aw_hs) r_awaddr <= axi.awaddr;
        if (w_w_hs) begin
            r_wdata <= axi.wdata;
            r_wstrb <= axi.wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RW; i++) r_regs[i] <= '0;
            r_status <= '0;
        end else begin
            r_status <= hw_status;
            if (w_commit && !w_wr_bad) begin
                for (int j = 0; j < 4; j++) begin
                    if (r_wstrb[j]) r_regs[w_wr_idx][8*j +: 8] <= r_wdata[8*j +: 8];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_out
        assign reg_out[32*gi +: 32] = r_regs[gi];
        assign reg_wr_pulse[gi]     = w_commit && !w_wr_bad && (w_wr_idx == IDX_W'(gi));
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_reg_slave
// Brief    : Directed scoreboard bench for axi4_lite_reg_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_reg_slave;

    localparam int NUM_RW = 8;
`ifdef AXI_SLAVE_WAIT_EN
    localparam int          WL         = 6;
    localparam int          RL         = 5;
    localparam logic [31:0] CONC_FIRST = 32'h5;
`else
    localparam int          WL         = 2;
    localparam int          RL         = 1;
    localparam logic [31:0] CONC_FIRST = 32'h0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [31:0]             hw_status = '0;
    logic [NUM_RW*32-1:0]    reg_out;
    logic [NUM_RW-1:0]       reg_wr_pulse;
    int                      n_checks = 0;
    int                      n_errors = 0;
    logic [1:0]              exp_b [$];
    logic [33:0]             exp_r [$];

    axi4_lite_if axi ();

    axi4_lite_reg_slave #(
        .BASE_ADDR(32'h0000_1000), .NUM_RW(NUM_RW),
        .ID_VALUE(32'hA5A5_0001), .WAIT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .axi(axi), .hw_status(hw_status),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation on each response handshake.
    always @(negedge clk) begin
        if (!rst && axi.bvalid && axi.bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
            else                   chk("bresp", axi.bresp, exp_b.pop_front());
        end
        if (!rst && axi.rvalid && axi.rready) begin
            if (exp_r.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
            else                   chk("rresp_rdata", {axi.rresp, axi.rdata}, exp_r.pop_front());
        end
    end

    task automatic send_aw_w(input bit do_aw, input bit do_w, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        bit aw_ok, w_ok;
        int n = 0;
        if (do_aw) begin axi.awvalid = 1'b1; axi.awaddr = addr; end
        if (do_w)  begin axi.wvalid = 1'b1; axi.wdata = data; axi.wstrb = strb; end
        while (axi.awvalid || axi.wvalid) begin
            @(negedge clk);
            aw_ok = axi.awvalid && axi.awready;
            w_ok  = axi.wvalid && axi.wready;
            @(posedge clk); #1;
            if (aw_ok) axi.awvalid = 1'b0;
            if (w_ok)  axi.wvalid  = 1'b0;
            n++;
            if (n > 50) begin
                chk("aw_w_handshake_timeout", 64'd1, 64'd0);
                axi.awvalid = 1'b0;
                axi.wvalid  = 1'b0;
            end
        end
    endtask

    task automatic wait_resp(input bit is_b, input int exp_lat,
                             input logic [NUM_RW-1:0] exp_pulse, input bit chk_pulse);
        int n = 1;
        forever begin
            @(negedge clk);
            if (chk_pulse) chk("wr_pulse", reg_wr_pulse, (n == 1) ? exp_pulse : '0);
            if (is_b ? axi.bvalid : axi.rvalid) break;
            if (n >= 50) break;
            @(posedge clk); #1;
            n++;
        end
        chk(is_b ? "b_latency" : "r_latency", n, exp_lat);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input logic [1:0] exp_resp,
                            input logic [NUM_RW-1:0] exp_pulse, input int hold);
        exp_b.push_back(exp_resp);
        if (hold > 0) axi.bready = 1'b0;
        if (w_lead > 0) begin
            send_aw_w(1'b0, 1'b1, addr, data, strb);
            repeat (w_lead - 1) begin @(posedge clk); #1; end
            send_aw_w(1'b1, 1'b0, addr, data, strb);
        end else begin
            send_aw_w(1'b1, 1'b1, addr, data, strb);
        end
        wait_resp(1'b1, WL, exp_pulse, 1'b1);
        for (int k = 0; k < hold; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_bvalid", axi.bvalid, 1'b1);
            chk("bp_bresp", axi.bresp, exp_resp);
            chk("bp_awready", axi.awready, 1'b0);
            @(posedge clk); #1;
        end
        axi.bready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        int n = 0;
        bit ok = 1'b0;
        exp_r.push_back({exp_resp, exp_data});
        axi.arvalid = 1'b1;
        axi.araddr  = addr;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = axi.arready;
            @(posedge clk); #1;
            n++;
        end
        axi.arvalid = 1'b0;
        if (!ok) chk("ar_handshake_timeout", 64'd1, 64'd0);
        wait_resp(1'b0, RL, '0, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0;
        axi.wstrb = '0; axi.bready = 1'b1; axi.arvalid = 1'b0; axi.araddr = '0;
        axi.rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", axi.awready, 1'b0);
        chk("rst_wready", axi.wready, 1'b0);
        chk("rst_arready", axi.arready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_bvalid_rvalid", {axi.bvalid, axi.rvalid}, 2'b00);
        chk("rst_resps", {axi.bresp, axi.rresp}, 4'b0000);
        chk("rst_rdata", axi.rdata, 32'h0);
        chk("rst_reg_out", reg_out[63:0], 64'h0);
        chk("rst_pulse", reg_wr_pulse, '0);
        @(posedge clk); #1;

        do_write(32'h1008, 32'hDEAD_BEEF, 4'hF, 0, 2'b00, 8'h01, 0);
        chk("reg0", reg_out[31:0], 32'hDEAD_BEEF);
        do_read(32'h1008, 32'hDEAD_BEEF, 2'b00);

        do_write(32'h100C, 32'hFFFF_FFFF, 4'hF, 0, 2'b00, 8'h02, 0);
        do_write(32'h100C, 32'h1122_3344, 4'b0101, 3, 2'b00, 8'h02, 0);
        chk("reg1_strobe", reg_out[63:32], 32'hFF22_FF44);

        do_read(32'h1000, 32'hA5A5_0001, 2'b00);
        do_write(32'h1000, 32'h1234_5678, 4'hF, 0, 2'b10, 8'h00, 0);
        do_read(32'h1000, 32'hA5A5_0001, 2'b00);
        do_read(32'h1028, 32'h0, 2'b10);
        do_read(32'h100A, 32'h0, 2'b10);
        do_read(32'h0FFC, 32'h0, 2'b10);
        do_write(32'h1028, 32'hFFFF_FFFF, 4'hF, 0, 2'b10, 8'h00, 0);

        hw_status = 32'h00C0_FFEE;
        repeat (2) begin @(posedge clk); #1; end
        do_read(32'h1004, 32'h00C0_FFEE, 2'b00);
        do_write(32'h1004, 32'h0, 4'hF, 0, 2'b10, 8'h00, 0);

        do_write(32'h1024, 32'h0000_0077, 4'hF, 0, 2'b00, 8'h80, 20);
        chk("reg7", reg_out[255:224], 32'h0000_0077);
        chk("reg0_kept", reg_out[31:0], 32'hDEAD_BEEF);

        // Read accepted on the same edge the write to reg2 commits.
        fork
            do_write(32'h1010, 32'h0000_0005, 4'hF, 0, 2'b00, 8'h04, 0);
            begin
                @(posedge clk); #1;
                do_read(32'h1010, CONC_FIRST, 2'b00);
            end
        join
        do_read(32'h1010, 32'h0000_0005, 2'b00);

        // Reset between the write handshake and its commit drops the write.
        send_aw_w(1'b1, 1'b1, 32'h1014, 32'hCAFE_F00D, 4'hF);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_awready", axi.awready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("midrst_bvalid", axi.bvalid, 1'b0);
            @(posedge clk); #1;
        end
        chk("midrst_reg3", reg_out[127:96], 32'h0);
        do_read(32'h1014, 32'h0, 2'b00);

        repeat (4) begin @(posedge clk); #1; end
        chk("b_queue_empty", exp_b.size(), 0);
        chk("r_queue_empty", exp_r.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_lite_reg_slave.md
Name: axi4_lite_reg_slave

Overview:
- AXI4-Lite slave register block: the responder for the bridge's AXI4-Lite master port.
- Gives UART host access to an ID register, a hardware status register and NUM_RW read/write control registers driven out to fabric.
- Independent read and write channel FSMs, byte strobes, SLVERR on bad accesses.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte base address of register window
- NUM_RW, 8, number of RW control registers (1..60)
- ID_VALUE, 32'hA5A5_0001, constant returned at offset 0x00
- WAIT_CYCLES, 4, extra response latency when wait-state injection is compiled in (0..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- axi  axi4_lite_if.slave  -  AXI4-Lite slave port. Fields used:
  - awaddr/araddr 32
  - wdata/rdata 32, wstrb 4
  - bresp/rresp 2
  - valid/ready pair on each of the five channels
- hw_status  in  32  sampled into STATUS register every cycle
- reg_out  out  NUM_RW*32  current RW register contents, reg i at bits [32i+31:32i]
- reg_wr_pulse  out  NUM_RW  one-cycle pulse on the cycle a write to reg i commits

Behaviour:
- Reset: rst synchronous, active-high; clock clk.
  - All RW regs 0, STATUS 0, reg_wr_pulse 0.
  - bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0.
  - awready/wready/arready forced 0 while rst=1.
  - Reset mid-transaction drops that transaction silently.
- Address map, offset = addr - BASE_ADDR:
  - 0x00 ID (RO).
  - 0x04 STATUS (RO, registered hw_status, 1-cycle lag).
  - 0x08+4i RW reg i, for i < NUM_RW.
- Access errors -> SLVERR (2'b10), no state change:
  - addr < BASE_ADDR;
  - offset >= 0x08+4*NUM_RW;
  - addr[1:0] != 0;
  - write to ID or STATUS.
  - Otherwise OKAY (2'b00). Reads of error addresses return rdata=0.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP (plus W_WAIT when the optional feature is compiled in).
  - awready=1 in W_IDLE and W_HAVE_DATA; wready=1 in W_IDLE and W_HAVE_ADDR.
  - AW and W are accepted in either order or in the same cycle; awaddr/wdata/wstrb are latched at their handshakes.
  - Commit cycle = cycle after both are held.
    - Byte j of the target reg is updated iff wstrb[j]; a strobe of 4'b0000 gives OKAY with no change.
    - reg_wr_pulse[i] is asserted on the commit cycle only for a valid RW target.
  - Commit -> W_RESP: bvalid=1 from the cycle after commit.
  - bvalid/bresp hold until bready; handshake -> W_IDLE.
  - Write latency: bvalid 2 cycles after the later of AW/W handshake.
- Read FSM states: R_IDLE, R_DATA (plus R_WAIT when the optional feature is compiled in).
  - arready=1 in R_IDLE only.
  - On AR handshake, rdata/rresp are registered from current contents and rvalid=1 next cycle (1-cycle latency).
  - rdata/rresp/rvalid stay stable until rready; handshake -> R_IDLE.
  - Back-to-back reads therefore have one idle cycle of arready between them.
- Read/write concurrency:
  - Read and write FSMs run fully concurrently.
  - A read sampled on the same edge as a write commit to the same reg returns the pre-write value.
  - A write commit and a hw_status update never conflict (STATUS is RO).
- Backpressure: bready/rready low for any number of cycles. Outputs stay stable, no new AW/W/AR is accepted, and there is no timeout inside this block.

Optional Feature:
- Macro: AXI_SLAVE_WAIT_EN.
- When defined:
  - After a write commit, the FSM enters W_WAIT for WAIT_CYCLES cycles before asserting bvalid.
  - After an AR handshake, the FSM enters R_WAIT for WAIT_CYCLES cycles before asserting rvalid.
  - rdata is sampled at the end of the wait.
  - 8-bit down-counter per channel; WAIT_CYCLES=0 behaves as without the macro.
  - Used to exercise the bridge's AXI timeout path.
- When undefined: no W_WAIT/R_WAIT states and no counters; latencies are as stated above.

Decomposition:
- Package axi4_lite_reg_pkg:
  - resp codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - offsets OFF_ID=0x00, OFF_STATUS=0x04, OFF_RW_BASE=0x08;
  - write_state_t and read_state_t enums.
- One sub-module, axi4_lite_reg_decode:
  - combinational address -> {is_id, is_status, rw_index, err} decoder;
  - shared by both FSMs (two instances).

Test Plan:
- Write 0x1008 data 0xDEADBEEF strb 4'hF, AW and W same cycle -> bresp 00 two cycles later; reg_out[31:0]=0xDEADBEEF; reg_wr_pulse[0] pulses once; read 0x1008 returns 0xDEADBEEF, rresp 00.
- W presented 3 cycles before AW, addr 0x100C data 0x11223344 strb 4'b0101 onto reg1=0xFFFFFFFF -> reg1=0xFF22FF44, bresp 00.
- Read 0x1000 -> 0xA5A50001. Write 0x1000 -> SLVERR, ID unchanged. Read 0x1028 (NUM_RW=8) -> SLVERR, rdata 0. Read 0x100A -> SLVERR.
- hw_status=0x00C0FFEE then read 0x1004 -> 0x00C0FFEE. With bready held low 20 cycles: bvalid/bresp stable, awready=0 throughout.
- Same cycle: AR 0x1010 and write commit to 0x1010 with 0x5 over 0x0 -> read returns 0x0; next read returns 0x5.
- With AXI_SLAVE_WAIT_EN and WAIT_CYCLES=4 -> rvalid 5 cycles after AR handshake; bvalid 6 cycles after the later of AW/W. Assert rst during W_WAIT -> bvalid=0 next cycle, reg unchanged if the commit had not occurred.
